serial_adder: RTL and testbench

- Bit-serial full adder: the additive counterpart to the full-subtractor datapath.
- Accepts two parallel WIDTH-bit operands plus carry-in, adds them LSB-first through a single registered full-adder cell over WIDTH cycles, then presents the parallel sum and carry-out with a one-cycle done pulse.
- Serves as the area-minimal arithmetic engine beside the combinational adder/subtractor blocks.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/full_adder_bit.sv | 18 +
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder built from two half adders and an OR.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic h1_s, h1_c, h2_c;

    assign h1_s = a ^ b;
    assign h1_c = a & b;
    assign s    = h1_s ^ cin;
    assign h2_c = h1_s & cin;
    assign co   = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one registered full-adder cell over WIDTH cycles.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state, state_d;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-2:0] s_sh;   // lower sum bits; the final bit goes straight to S
    logic [CNT_W-1:0] cnt;
    logic             c;
    logic             s, co;
    logic             last;

    full_adder_bit u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (c),
        .s   (s),
        .co  (co)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            Ovf   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= A;
                        b_sh <= B;
                        c    <= Cin;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    s_sh <= (WIDTH-1)'({s, s_sh} >> 1);
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    c    <= co;
                    if (last) begin
                        S    <= {s, s_sh};
                        Cout <= co;
                        done <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        // c is the carry into the MSB, co the carry out of it.
                        Ovf  <= c ^ co;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
// Ovf checks are compiled in when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A, B;
    logic             Cin;
    logic             busy, done;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             Ovf;
`endif

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] prev_s;
    logic             prev_c;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One operation; poke re-asserts start with other operands mid-SHIFT and during DONE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input bit poke, input bit verbose);
        logic [WIDTH:0] sum;
        int  n;
        bit  held;
        bit  extra;
        sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        held = 1'b1;
        @(negedge clk);
        while (busy) @(negedge clk);
        A = a; B = b; Cin = cin; start = 1'b1;
        @(posedge clk); #1;
        if (verbose) check("busy_at_accept", busy, 1);
        start = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom);
        n = 0;
        while (!done && n < 40) begin
            if (S !== prev_s || Cout !== prev_c) held = 1'b0;
            if (poke && n == 2) begin
                start = 1'b1; A = 8'h50; B = 8'h50;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("held_between_done", held, 1);
        if (verbose) check("latency", n, WIDTH);
        if (verbose) check("busy_at_done", busy, 1);
        check("sum", {Cout, S}, sum);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", Ovf, (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]));
`endif
        prev_s = S;
        prev_c = Cout;
        if (poke) begin
            start = 1'b1; A = 8'h50; B = 8'h50; Cin = 1'b0;
            @(posedge clk); #1;
            start = 1'b0;
            check("done_pulse_end", done, 0);
            check("busy_after_done", busy, 0);
            extra = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(posedge clk); #1;
                if (done || busy) extra = 1'b1;
            end
            check("no_second_done", extra, 0);
            check("sum_kept", {Cout, S}, sum);
        end
    endtask

    initial begin
        bit extra;
        logic [WIDTH-1:0] ra, rb;
        logic rc;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        prev_s = '0; prev_c = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_S", S, 0);
        check("rst_Cout", Cout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk); rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1);
        run_op(8'h03, 8'h04, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of an operation abandons it.
        @(negedge clk);
        A = 8'hAA; B = 8'h55; Cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_S", S, 0);
        check("midrst_Cout", Cout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk); rst = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) extra = 1'b1;
        end
        check("midrst_no_done", extra, 0);
        prev_s = '0; prev_c = 1'b0;
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 1000; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            run_op(ra, rb, rc, 1'b0, (k % 100) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
